addsub_accumulator: RTL and testbench

ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_accumulator_if.sv | 47 ++++
 rtl/adder_subtractor.sv | 23 ++
 rtl/addsub_accumulator.sv | 112 +++++++++++
 tb/tb_addsub_accumulator.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared encodings for the add/subtract accumulator: FSM states and op codes.
package addsub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_accumulator_if.sv
// Operand/result bus of the accumulator; master drives operands, slave returns results.
interface addsub_accumulator_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);

    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] operand;
    logic             clear;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             overflow;
    logic             sticky_ovf;
    logic             out_valid;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid,
        output op,
        output operand,
        output clear,
        input  in_ready,
        input  acc,
        input  carry,
        input  overflow,
        input  sticky_ovf,
        input  out_valid,
        input  op_count
    );

    modport slave (
        input  in_valid,
        input  op,
        input  operand,
        input  clear,
        output in_ready,
        output acc,
        output carry,
        output overflow,
        output sticky_ovf,
        output out_valid,
        output op_count
    );

endinterface

// File: rtl/adder_subtractor.sv
// Ripple-style add/subtract: m=0 gives a+b, m=1 gives a-b as a + ~b + 1.
module adder_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             v
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff = b ^ {WIDTH{m}};
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, m};
    assign sum   = full[WIDTH-1:0];
    assign c_out = full[WIDTH];
    // Signed overflow: both effective operands agree in sign but the result does not.
    assign v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_accumulator.sv
// Handshaked accumulator: one add/subtract in flight, IDLE -> CALC -> DONE per operation.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    addsub_accumulator_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             op_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic             ovf_q;
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             v;

    adder_subtractor #(
        .WIDTH (WIDTH)
    ) u_adder_subtractor (
        .m     (op_q),
        .a     (acc_q),
        .b     (operand_q),
        .sum   (sum),
        .c_out (c_out),
        .v     (v)
    );

    assign accept = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else if (bus.clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StCalc;
            StCalc:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) && !bus.clear;
        out_valid = (state_q == StDone);
    end

    // Operands are latched only on the accepting edge so later input changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_ADD;
            operand_q <= '0;
        end else if (accept) begin
            op_q      <= bus.op;
            operand_q <= bus.operand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (bus.clear) begin
            acc_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else if (state_q == StCalc) begin
            acc_q    <= sum;
            carry_q  <= c_out;
            ovf_q    <= v;
            sticky_q <= sticky_q | v;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.acc        = acc_q;
    assign bus.carry      = carry_q;
    assign bus.overflow   = ovf_q;
    assign bus.sticky_ovf = sticky_q;
    assign bus.op_count   = cnt_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Randomized and directed bench for addsub_accumulator against a timestamped arithmetic model.
module tb_addsub_accumulator;

    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int MOD  = 1 << W;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    addsub_accumulator_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    addsub_accumulator #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Model: result of an accepted op lands one edge after acceptance; cycle of that landing
    // is remembered so out_valid and readiness follow from timestamps.
    int m_acc     = 0;
    int m_cnt     = 0;
    int m_cyc     = 0;
    int m_res_cyc = -10;
    bit m_carry   = 0;
    bit m_ovf     = 0;
    bit m_sticky  = 0;
    bit m_pend    = 0;
    bit m_pop     = 0;
    int m_popd    = 0;

    function automatic int sx(input int val);
        return (val >= MOD / 2) ? val - MOD : val;
    endfunction

    function automatic bit m_ready();
        return !m_pend && (m_res_cyc != m_cyc) && !bus.clear;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 0; m_cnt = 0; m_cyc = 0; m_res_cyc = -10;
            m_carry = 0; m_ovf = 0; m_sticky = 0; m_pend = 0;
        end else begin
            bit rdy;
            int sv;
            rdy = m_ready();
            m_cyc++;
            if (bus.clear) begin
                m_acc = 0; m_cnt = 0; m_carry = 0; m_ovf = 0; m_sticky = 0; m_pend = 0;
            end else if (m_pend) begin
                if (m_pop == 1'b0) begin
                    m_carry = (m_acc + m_popd) >= MOD;
                    sv      = sx(m_acc) + sx(m_popd);
                    m_acc   = (m_acc + m_popd) % MOD;
                end else begin
                    m_carry = m_acc >= m_popd;
                    sv      = sx(m_acc) - sx(m_popd);
                    m_acc   = (m_acc - m_popd + MOD) % MOD;
                end
                m_ovf     = (sv > MOD / 2 - 1) || (sv < -(MOD / 2));
                m_sticky  = m_sticky | m_ovf;
                m_cnt     = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                m_res_cyc = m_cyc;
                m_pend    = 0;
            end else if (rdy && bus.in_valid) begin
                m_pend = 1;
                m_pop  = bus.op;
                m_popd = int'(bus.operand);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("acc", 32'(bus.acc), 32'(m_acc));
            chk("carry", 32'(bus.carry), 32'(m_carry));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("sticky_ovf", 32'(bus.sticky_ovf), 32'(m_sticky));
            chk("op_count", 32'(bus.op_count), 32'(m_cnt));
            chk("out_valid", 32'(bus.out_valid), 32'(m_res_cyc == m_cyc));
            chk("in_ready", 32'(bus.in_ready), 32'(m_ready()));
        end
    end

    // Offer an op and hold it until accepted; returns 2 time units after the accepting edge.
    task automatic drive_op(input bit op, input int opd);
        bit r;
        bus.op       = op;
        bus.operand  = W'(opd);
        bus.in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #2;
            if (r) break;
            if (n == 19) chk("accept_timeout", 32'(0), 32'(1));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic op_lit(input bit op, input int opd, input int e_acc, input bit e_c,
                          input bit e_v, input string name);
        drive_op(op, opd);
        @(negedge clk);
        chk({name, "_ov_calc"}, 32'(bus.out_valid), 32'(0));
        @(negedge clk);
        chk({name, "_ov_done"}, 32'(bus.out_valid), 32'(1));
        chk({name, "_acc"}, 32'(bus.acc), 32'(e_acc));
        chk({name, "_carry"}, 32'(bus.carry), 32'(e_c));
        chk({name, "_ovf"}, 32'(bus.overflow), 32'(e_v));
    endtask

    task automatic do_clear();
        @(posedge clk);
        #2 bus.clear = 1'b1;
        @(posedge clk);
        #2 bus.clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int accepts;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = 1'b0;
        bus.operand  = '0;
        bus.clear    = 1'b0;
        chk_on       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_acc", 32'(bus.acc), 32'(0));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_op_count", 32'(bus.op_count), 32'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Add chain from zero: 5 then 4 overflows signed (5+4=9 > 7).
        op_lit(1'b0, 5, 5, 1'b0, 1'b0, "add5");
        op_lit(1'b0, 4, 9, 1'b0, 1'b1, "add4");
        chk("chain_sticky", 32'(bus.sticky_ovf), 32'(1));

        // Clear while an op is in CALC, with the next operand already offered.
        drive_op(1'b0, 2);
        bus.in_valid = 1'b1;
        bus.clear    = 1'b1;
        @(negedge clk);
        chk("clr_in_ready", 32'(bus.in_ready), 32'(0));
        chk("clr_ov", 32'(bus.out_valid), 32'(0));
        @(posedge clk);
        #2 bus.clear = 1'b0;
        @(negedge clk);
        chk("clr_acc", 32'(bus.acc), 32'(0));
        chk("clr_sticky", 32'(bus.sticky_ovf), 32'(0));
        chk("clr_ov_after", 32'(bus.out_valid), 32'(0));
        chk("clr_ready_after", 32'(bus.in_ready), 32'(1));
        @(posedge clk);
        #2 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_next_calc", 32'(bus.in_ready), 32'(0));
        @(negedge clk);
        chk("clr_next_ov", 32'(bus.out_valid), 32'(1));
        chk("clr_next_acc", 32'(bus.acc), 32'(2));

        // Wrap: 1 + 15 -> 0 with carry, no signed overflow.
        do_clear();
        op_lit(1'b0, 1, 1, 1'b0, 1'b0, "wrap_add1");
        op_lit(1'b0, 15, 0, 1'b1, 1'b0, "wrap_add15");

        // Subtract with borrow, then exact subtract.
        do_clear();
        op_lit(1'b0, 3, 3, 1'b0, 1'b0, "sub_pre3");
        op_lit(1'b1, 5, 14, 1'b0, 1'b0, "sub5");
        do_clear();
        op_lit(1'b0, 7, 7, 1'b0, 1'b0, "sub_pre7");
        op_lit(1'b1, 7, 0, 1'b1, 1'b0, "sub7");

        // Reset in the middle of CALC.
        op_lit(1'b0, 5, 5, 1'b0, 1'b0, "prerst_add5");
        drive_op(1'b0, 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_acc", 32'(bus.acc), 32'(0));
        chk("midrst_count", 32'(bus.op_count), 32'(0));
        chk("midrst_ov", 32'(bus.out_valid), 32'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(bus.in_ready), 32'(1));
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_ov", 32'(bus.out_valid), 32'(0));
        end

        // Saturation with in_valid held high: 260 ops.
        do_clear();
        bus.op       = 1'b0;
        bus.operand  = W'($urandom_range(0, MOD - 1));
        bus.in_valid = 1'b1;
        pulses       = 0;
        accepts      = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
            if (bus.in_ready && bus.in_valid) accepts++;
            @(posedge clk);
            #2;
            if (accepts == 260) bus.in_valid = 1'b0;
            if (pulses == 260) break;
        end
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        chk("sat_accepts", 32'(accepts), 32'(260));
        chk("sat_pulses", 32'(pulses), 32'(260));
        chk("sat_op_count", 32'(bus.op_count), 32'(CMAX));

        // Random traffic including clears, input churn and one reset pulse.
        do_clear();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.op       = $urandom_range(0, 1);
            bus.operand  = W'($urandom_range(0, MOD - 1));
            bus.clear    = ($urandom_range(0, 19) == 0);
            rst_n        = (i != 200);
        end
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        rst_n        = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
